// File: rtl/upsample_nearest_2x2.sv
// upsample_nearest_2x2: streaming nearest-neighbour 2x upsampler; each row is emitted
// twice per pixel while being captured, then replayed once from a single line buffer.
module upsample_nearest_2x2 #(
  parameter int DATA_WIDHT = 32,
  parameter int IMG_WIDHT  = 150,
  parameter int IMG_HEIGHT = 150
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic [DATA_WIDHT-1:0] Data_In,
  input  logic                  Valid_In,
  output logic                  Ready_In,
  output logic [DATA_WIDHT-1:0] Data_Out,
  output logic                  Valid_Out,
  output logic                  Last_Out
);
  localparam int CW = $clog2(IMG_WIDHT) + 1;
  localparam int RW = $clog2(IMG_HEIGHT) + 1;
  localparam int AW = $clog2(IMG_WIDHT);
  typedef enum logic {FILL, REPLAY} state_t;
  state_t                state;
  logic                  phase;
  logic [CW-1:0]         col;
  logic [RW-1:0]         row;
  logic [DATA_WIDHT-1:0] line_buf [IMG_WIDHT];
  logic                  col_end, row_end, accept;
  always_comb begin
    Ready_In = !rst && state == FILL && !phase;
    accept   = Ready_In && Valid_In;
    col_end  = col == CW'(IMG_WIDHT - 1);
    row_end  = row == RW'(IMG_HEIGHT - 1);
  end
  // Buffer holds no reset: its contents are only read after a full row has been written.
  always_ff @(posedge clk)
    if (accept) line_buf[col[AW-1:0]] <= Data_In;
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state     <= FILL;
      phase     <= 1'b0;
      col       <= '0;
      row       <= '0;
      Data_Out  <= '0;
      Valid_Out <= 1'b0;
      Last_Out  <= 1'b0;
    end else begin
      Last_Out <= 1'b0;
      if (state == FILL) begin
        if (!phase) begin
          Valid_Out <= Valid_In;
          if (Valid_In) begin
            Data_Out <= Data_In;
            phase    <= 1'b1;
          end
        end else begin
          Valid_Out <= 1'b1;
          phase     <= 1'b0;
          col       <= col_end ? '0 : col + 1'b1;
          if (col_end) state <= REPLAY;
        end
      end else begin
        Data_Out  <= line_buf[col[AW-1:0]];
        Valid_Out <= 1'b1;
        phase     <= !phase;
        if (phase) begin
          col <= col_end ? '0 : col + 1'b1;
          if (col_end) begin
            state    <= FILL;
            row      <= row_end ? '0 : row + 1'b1;
            Last_Out <= row_end;
          end
        end
      end
    end
  end
endmodule

// File: tb/tb_upsample_nearest_2x2.sv
// tb_upsample_nearest_2x2: directed + randomized checks of the 2x upsampler against
// a frame-level reference that maps each output index back to its source pixel.
module tb_upsample_nearest_2x2;
  logic        clk = 1'b0, rst = 1'b1, sel = 1'b0;
  logic [31:0] data_in = '0;
  logic        valid_in = 1'b0;
  logic        rdy0, rdy1, vo0, vo1, lo0, lo1, rdy, vout, lout;
  logic [31:0] do0, do1, dout;
  int          W = 3, H = 2;
  int          compared = 0, mismatched = 0;
  logic [31:0] frame_px [$];

  always #5 clk = ~clk;

  upsample_nearest_2x2 #(.DATA_WIDHT(32), .IMG_WIDHT(3), .IMG_HEIGHT(2)) u0 (
    .clk(clk), .rst(rst), .Data_In(data_in), .Valid_In(valid_in && !sel), .Ready_In(rdy0),
    .Data_Out(do0), .Valid_Out(vo0), .Last_Out(lo0));
  upsample_nearest_2x2 #(.DATA_WIDHT(32), .IMG_WIDHT(2), .IMG_HEIGHT(1)) u1 (
    .clk(clk), .rst(rst), .Data_In(data_in), .Valid_In(valid_in && sel), .Ready_In(rdy1),
    .Data_Out(do1), .Valid_Out(vo1), .Last_Out(lo1));

  always_comb begin
    rdy  = sel ? rdy1 : rdy0;
    vout = sel ? vo1 : vo0;
    lout = sel ? lo1 : lo0;
    dout = sel ? do1 : do0;
  end

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    compared++;
    assert (obs === exp) else begin
      mismatched++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  // mode 0: valid held high, 1: valid on every other ready cycle, 2: random valid.
  // Output index p within a frame: row pair r = q/(4W); first 2W outputs are the
  // captured row (pairs of copies), next 2W the replayed row.
  task automatic run(input int n, input int mode, input int stop_cyc);
    int sent = 0, rc = 0, gap = 0, cyc = 0, got = 0, lasts = 0;
    int wh, q, s, rep, t, c;
    wh = W * H;
    while (stop_cyc > 0 ? cyc < stop_cyc : (got < 4 * n && cyc < 4000)) begin
      @(negedge clk);
      cyc++;
      if (vout) begin
        q   = got % (4 * wh);
        s   = q % (4 * W);
        rep = s / (2 * W);
        t   = s % (2 * W);
        c   = t / 2;
        chk("data", dout, frame_px[(got / (4 * wh)) * wh + (q / (4 * W)) * W + c]);
        chk("last", {31'd0, lout}, {31'd0, q == 4 * wh - 1});
        chk("ready", {31'd0, rdy}, {31'd0, rep == 0 ? (t % 2 == 1 && c != W - 1) : (t == 2 * W - 1)});
        chk("gap", {31'd0, gap == 0 || got == 0 || (mode != 0 && rep == 0 && t % 2 == 0)}, 32'd1);
        lasts += int'(lout);
        got++;
        gap = 0;
      end else begin
        chk("bubble_ready", {31'd0, rdy}, 32'd1);
        gap++;
      end
      if (rdy && sent < n) begin
        valid_in = mode == 0 ? 1'b1 : mode == 1 ? (rc % 2 == 0) : ($urandom_range(0, 1) == 1);
        rc++;
        data_in = valid_in ? frame_px[sent] : (32'hBAD0_0000 | $urandom_range(0, 255));
        if (valid_in) sent++;
      end else begin
        valid_in = sent < n && (mode == 0 || $urandom_range(0, 1) == 1);
        data_in  = 32'hBAD0_0000 | $urandom_range(0, 255);
      end
    end
    if (stop_cyc == 0) begin
      chk("out_count", got, 4 * n);
      chk("last_count", lasts, n / wh);
    end
  endtask

  task automatic pulse_reset();
    #2 rst = 1'b1;
    #1;
    chk("rst_valid", {31'd0, vout}, 32'd0);
    chk("rst_data", dout, 32'd0);
    chk("rst_last", {31'd0, lout}, 32'd0);
    chk("rst_ready", {31'd0, rdy}, 32'd0);
    valid_in = 1'b0;
    @(negedge clk);
    rst = 1'b0;
    #1 chk("post_rst_ready", {31'd0, rdy}, 32'd1);
  endtask

  initial begin
    repeat (2) @(negedge clk);
    chk("init_valid", {31'd0, vout}, 32'd0);
    chk("init_data", dout, 32'd0);
    chk("init_last", {31'd0, lout}, 32'd0);
    chk("init_ready", {31'd0, rdy}, 32'd0);
    rst = 1'b0;
    #1 chk("init_ready_rel", {31'd0, rdy}, 32'd1);
    frame_px = '{1, 2, 3, 4, 5, 6};
    run(6, 0, 0);
    run(6, 1, 0);
    @(negedge clk);
    chk("a5_ready_k", {31'd0, rdy}, 32'd1);
    valid_in = 1'b1;
    data_in  = 32'hA5;
    @(negedge clk);
    valid_in = 1'b1;
    data_in  = 32'h5A;
    chk("a5_data_k1", dout, 32'hA5);
    chk("a5_valid_k1", {31'd0, vout}, 32'd1);
    chk("a5_ready_k1", {31'd0, rdy}, 32'd0);
    @(negedge clk);
    valid_in = 1'b0;
    chk("a5_data_k2", dout, 32'hA5);
    chk("a5_valid_k2", {31'd0, vout}, 32'd1);
    chk("a5_ready_k2", {31'd0, rdy}, 32'd1);
    pulse_reset();
    frame_px = '{1, 2, 3, 4, 5, 6, 7, 8, 9, 10, 11, 12};
    run(12, 0, 0);
    frame_px = '{1, 2, 3, 4, 5, 6};
    run(6, 0, 9);
    pulse_reset();
    run(6, 0, 0);
    frame_px.delete();
    for (int i = 0; i < 12; i++) frame_px.push_back($urandom);
    run(12, 2, 0);
    sel = 1'b1;
    W = 2;
    H = 1;
    frame_px = '{9, 8};
    run(2, 0, 0);
    frame_px.delete();
    for (int i = 0; i < 6; i++) frame_px.push_back($urandom);
    run(6, 2, 0);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
    $finish;
  end
endmodule

// File: doc/upsample_nearest_2x2.md
Name: upsample_nearest_2x2

Overview:
- Streaming nearest-neighbour 2x upsampler, the inverse of the 1x1/stride-2 downsampling stage.
- Accepts an IMG_WIDHT x IMG_HEIGHT raster pixel stream and emits a 2*IMG_WIDHT x 2*IMG_HEIGHT raster stream.
- Each input pixel is replicated horizontally (twice per row) and vertically (its row replayed once from an internal line buffer).
- Sits between feature-map stages on the decoder side of the convolution pipeline.

Parameters:
- DATA_WIDHT, 32, pixel word width in bits.
- IMG_WIDHT, 150, input image width in pixels (>=2).
- IMG_HEIGHT, 150, input image height in rows (>=1).

Ports:
- clk  input  1  single clock, all logic on rising edge.
- rst  input  1  asynchronous, active-high reset.
- Data_In  input  DATA_WIDHT  input pixel, raster order.
- Valid_In  input  1  Data_In is valid.
- Ready_In  output  1  block can accept a pixel this cycle; transfer occurs when Valid_In && Ready_In.
- Data_Out  output  DATA_WIDHT  upsampled pixel, registered.
- Valid_Out  output  1  Data_Out is valid, registered; no downstream backpressure.
- Last_Out  output  1  registered; high with the final output pixel of a frame.

Behaviour:
- Reset (async, rst=1): state=FILL, phase=0, col=0, row=0, Data_Out=0, Valid_Out=0, Last_Out=0. Ready_In is forced 0 while rst=1. Line-buffer contents are don't-care. Reset mid-frame discards the frame; the first pixel accepted after reset is pixel (0,0).
- Storage: IMG_WIDHT-entry line buffer, DATA_WIDHT wide. Counters: col is 0..IMG_WIDHT-1, row is 0..IMG_HEIGHT-1, sized $clog2(max)+1. phase is 1 bit.
- Ready_In = (state==FILL && phase==0), combinational, gated by rst.
- FILL, phase 0:
  - If Valid_In: Data_Out<=Data_In, Valid_Out<=1, buf[col]<=Data_In, phase<=1.
  - Else: Valid_Out<=0 (bubble), Data_Out holds.
- FILL, phase 1: Valid_Out<=1, Data_Out holds (second copy), phase<=0.
  - If col==IMG_WIDHT-1: col<=0, state<=REPLAY.
  - Else: col<=col+1.
- Effect of FILL: an accepted input pixel appears on Data_Out for exactly 2 consecutive cycles, starting the cycle after acceptance (latency 1). Maximum input rate is 1 pixel per 2 cycles.
- REPLAY: Ready_In=0. Each cycle: Data_Out<=buf[col], Valid_Out<=1, phase toggles. col increments after phase 1.
  - Lasts exactly 2*IMG_WIDHT cycles, with no bubbles.
  - At col==IMG_WIDHT-1 && phase==1: col<=0, state<=FILL.
  - On the same cycle, if row==IMG_HEIGHT-1: row<=0 and Last_Out<=1 with this pixel. Otherwise row<=row+1.
- Last_Out is 1 for exactly one Valid_Out cycle per frame and 0 otherwise.
- Boundaries:
  - Back-to-back frames need no idle cycle; the next frame's first pixel may be accepted on the cycle right after the final REPLAY cycle.
  - Valid_In while Ready_In=0 is ignored. Upstream must hold its data.
  - Buffer write (FILL) and read (REPLAY) never overlap.
  - IMG_HEIGHT=1: the frame is one FILL row plus one REPLAY row, with Last_Out on the last REPLAY pixel.
- Output count per frame: 4*IMG_WIDHT*IMG_HEIGHT Valid_Out cycles.

Test Plan:
- IMG_WIDHT=3, IMG_HEIGHT=2, inputs 1..6 streamed with Valid_In held high.
  - Required output sequence: 1,1,2,2,3,3,1,1,2,2,3,3,4,4,5,5,6,6,4,4,5,5,6,6.
  - Valid_Out is continuous after the first acceptance.
  - Last_Out is high only on the 24th output.
- Same configuration with Valid_In toggling 1/0 every other Ready_In cycle.
  - Same 24-value sequence; Valid_Out bubbles appear only in FILL rows.
  - Input data presented while Ready_In=0 never reaches the output.
- Check Ready_In with input value 0xA5 accepted at edge k: Data_Out=0xA5 and Valid_Out=1 in cycles k+1 and k+2. Ready_In=0 in cycle k+1 and for all 6 REPLAY cycles.
- Two frames back-to-back (inputs 1..6, then 7..12).
  - Second frame's first output is 7, one cycle after the first Last_Out.
  - Exactly 48 Valid_Out cycles in total; Last_Out fires twice.
- Assert rst for one cycle in the middle of the REPLAY of row 0.
  - Valid_Out, Data_Out and Last_Out are 0 immediately (asynchronously); Ready_In is 0 during reset and 1 after it.
  - A new frame 1..6 then produces the correct 24-value sequence.
- IMG_WIDHT=2, IMG_HEIGHT=1, inputs 9,8.
  - Output 9,9,8,8,9,9,8,8, with Last_Out on the 8th output.
